// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: parametrised N-floor elevator controller.
// Latches floor calls and schedules them SCAN-style (keep direction while calls
// lie ahead, otherwise reverse). Door dwell and floor travel are timed in 'tick'
// units. Occupancy is counted while the door is open, and overload holds the door.
// Optional feature macro: ELEV_PARK_EN (return an idle car to floor 0).
module elevator_ctrl_n #(
    parameter int  FLOORS     = 4,
    parameter int  MOVE_TICKS = 2,
    parameter int  DOOR_TICKS = 3,
    parameter int  CAPACITY   = 5,
    parameter int  PARK_TICKS = 8,
    localparam int FLOOR_W    = $clog2(FLOORS),
    localparam int CNT_W      = $clog2(CAPACITY + 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [FLOORS-1:0]  call_req,
    input  logic               up,
    input  logic               down,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [CNT_W-1:0]   count,
    output logic               alarm,
    output logic [FLOORS-1:0]  pending
);
    localparam int MT_W = $clog2(MOVE_TICKS + 1);
    localparam int DT_W = $clog2(DOOR_TICKS + 1);
    localparam logic [MT_W-1:0]    MOVE_LAST = MT_W'(MOVE_TICKS - 1);
    localparam logic [DT_W-1:0]    DOOR_LAST = DT_W'(DOOR_TICKS - 1);
    localparam logic [DT_W-1:0]    DOOR_END  = DT_W'(DOOR_TICKS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [CNT_W-1:0]   CNT_CAP   = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(CAPACITY + 1);

    // Reject out-of-range parameters at elaboration.
    if (FLOORS < 2 || FLOORS > 16 || MOVE_TICKS < 1 || DOOR_TICKS < 1 ||
        CAPACITY < 1 || PARK_TICKS < 1) begin : g_param_check
        $error("elevator_ctrl_n: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_up_q, dir_up_d;
    logic               moving_q, moving_d;
    logic               door_open_q, door_open_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic [MT_W-1:0]    move_tmr_q, move_tmr_d;
    logic [DT_W-1:0]    door_tmr_q, door_tmr_d;

    logic               alarm_s;
    logic               above_s, below_s;
    state_t             sched_state_s;
    logic               sched_dir_s;
    logic [FLOORS-1:0]  sched_clr_s;
    logic [FLOORS-1:0]  clr_s;
    logic [FLOORS-1:0]  call_mask_s;
    logic [FLOOR_W-1:0] next_floor_s;
    logic               at_limit_s;
    logic               door_done_s;
    logic               park_go_s, park_active_s, park_cancel_s;

    assign alarm_s      = (count_q > CNT_CAP);
    assign next_floor_s = dir_up_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    assign at_limit_s   = dir_up_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
    assign door_done_s  = (door_tmr_q == DOOR_END) || (tick && (door_tmr_q == DOOR_LAST));

`ifdef ELEV_PARK_EN
    localparam int PK_W = $clog2(PARK_TICKS + 1);
    localparam logic [PK_W-1:0] PARK_LAST = PK_W'(PARK_TICKS - 1);

    logic            park_q, park_d;
    logic [PK_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            idle_empty_s;

    assign idle_empty_s  = (state_q == S_IDLE) && (pending_q == '0) && (floor_q != '0);
    assign park_go_s     = idle_empty_s && tick && (idle_cnt_q == PARK_LAST);
    assign park_active_s = park_q;
    assign park_cancel_s = park_q && (state_q == S_MOVE) && (pending_q != '0);

    // Idle tick counter and park flag (flag lives only while the parking move lasts).
    always_comb begin
        if (idle_empty_s && tick) begin
            idle_cnt_d = park_go_s ? '0 : (idle_cnt_q + PK_W'(1));
        end else if (idle_empty_s) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = '0;
        end
        park_d = park_go_s || (park_q && (state_q == S_MOVE) && (state_d == S_MOVE));
    end

    // Park state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            park_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            park_q     <= park_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign park_go_s     = 1'b0;
    assign park_active_s = 1'b0;
    assign park_cancel_s = 1'b0;
`endif

    // SCAN scheduler: serve this floor, else keep direction, else reverse, else idle.
    always_comb begin
        above_s = 1'b0;
        below_s = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            above_s = above_s | (pending_q[i] & (FLOOR_W'(i) > floor_q));
            below_s = below_s | (pending_q[i] & (FLOOR_W'(i) < floor_q));
        end
        sched_clr_s = '0;
        if (pending_q[floor_q]) begin
            sched_state_s = S_DOOR;
            sched_dir_s   = dir_up_q;
            sched_clr_s   = FLOORS'(1) << floor_q;
        end else if (dir_up_q ? above_s : below_s) begin
            sched_state_s = S_MOVE;
            sched_dir_s   = dir_up_q;
        end else if (dir_up_q ? below_s : above_s) begin
            sched_state_s = S_MOVE;
            sched_dir_s   = ~dir_up_q;
        end else begin
            sched_state_s = S_IDLE;
            sched_dir_s   = dir_up_q;
        end
    end

    // Next-state logic: state, floor, direction, timers and serviced-call clears.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        move_tmr_d = move_tmr_q;
        door_tmr_d = door_tmr_q;
        clr_s      = '0;
        case (state_q)
            S_IDLE: begin
                move_tmr_d = '0;
                door_tmr_d = '0;
                if (park_go_s) begin
                    state_d  = S_MOVE;
                    dir_up_d = 1'b0;
                end else begin
                    state_d  = sched_state_s;
                    dir_up_d = sched_dir_s;
                    clr_s    = sched_clr_s;
                end
            end
            S_MOVE: begin
                door_tmr_d = '0;
                if (park_cancel_s) begin
                    state_d    = S_IDLE;
                    move_tmr_d = '0;
                end else if (tick && (move_tmr_q == MOVE_LAST)) begin
                    move_tmr_d = '0;
                    if (at_limit_s) begin
                        state_d = S_IDLE;
                    end else if (pending_q[next_floor_s]) begin
                        floor_d = next_floor_s;
                        state_d = S_DOOR;
                        clr_s   = FLOORS'(1) << next_floor_s;
                    end else if (park_active_s && (next_floor_s == '0)) begin
                        floor_d = next_floor_s;
                        state_d = S_IDLE;
                    end else begin
                        floor_d = next_floor_s;
                        state_d = S_MOVE;
                    end
                end else if (tick) begin
                    move_tmr_d = move_tmr_q + MT_W'(1);
                end else begin
                    move_tmr_d = move_tmr_q;
                end
            end
            S_DOOR: begin
                move_tmr_d = '0;
                if (call_req[floor_q]) begin
                    door_tmr_d = '0;
                end else if (!alarm_s && door_done_s) begin
                    state_d    = sched_state_s;
                    dir_up_d   = sched_dir_s;
                    clr_s      = sched_clr_s;
                    door_tmr_d = '0;
                end else if (tick && (door_tmr_q != DOOR_END)) begin
                    door_tmr_d = door_tmr_q + DT_W'(1);
                end else begin
                    door_tmr_d = door_tmr_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: call latching (own floor ignored while door is open) and occupancy.
    always_comb begin
        call_mask_s = call_req;
        if (state_q == S_DOOR) begin
            call_mask_s[floor_q] = 1'b0;
        end else begin
            call_mask_s = call_req;
        end
        pending_d = (pending_q | call_mask_s) & ~clr_s;
        if ((state_q == S_DOOR) && up && !down && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else if ((state_q == S_DOOR) && down && !up && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Output decode from the next state so moving/door_open are registered.
    always_comb begin
        moving_d    = (state_d == S_MOVE);
        door_open_d = (state_d == S_DOOR);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            dir_up_q    <= 1'b1;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
            count_q     <= '0;
            pending_q   <= '0;
            move_tmr_q  <= '0;
            door_tmr_q  <= '0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            moving_q    <= moving_d;
            door_open_q <= door_open_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            move_tmr_q  <= move_tmr_d;
            door_tmr_q  <= door_tmr_d;
        end
    end

    assign floor     = floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign door_open = door_open_q;
    assign count     = count_q;
    assign alarm     = alarm_s;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed bench for elevator_ctrl_n (4 floors, 2 move ticks,
// 3 door ticks, capacity 5). A per-clock vector table plus hand sequences.
module tb_elevator_ctrl_n;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] call_req = 4'b0000;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [1:0] floor;
    logic       dir_up, moving, door_open, alarm;
    logic [2:0] count;
    logic [3:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    elevator_ctrl_n #(
        .FLOORS(4), .MOVE_TICKS(2), .DOOR_TICKS(3), .CAPACITY(5), .PARK_TICKS(8)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .call_req(call_req),
        .up(up), .down(down), .floor(floor), .dir_up(dir_up), .moving(moving),
        .door_open(door_open), .count(count), .alarm(alarm), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  call;
        logic        up_i;
        logic        dn_i;
        logic        tk_i;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic [3:0] c, input logic u, input logic d,
                                input logic t, input logic [1:0] f, input logic dr,
                                input logic m, input logic o, input logic [2:0] cn,
                                input logic a, input logic [3:0] p);
        vec_t v;
        v.call = c; v.up_i = u; v.dn_i = d; v.tk_i = t;
        v.exp  = {f, dr, m, o, cn, a, p};
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {floor, dir_up, moving, door_open, count, alarm, pending};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b0;
        repeat (3) clk1();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic pulse_call(input logic [3:0] c);
        call_req = c;
        clk1();
        call_req = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; call_req = 4'b0000; up = 1'b0; down = 1'b0;
        clk1();
        clk1();
        reset = 1'b0;
        clk1();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // call, up, dn, tick -> floor, dir, moving, door, count, alarm, pending
        vecs[0]  = mk(4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0100);
        vecs[1]  = mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0100);
        vecs[2]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0100);
        vecs[3]  = mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0100);
        vecs[4]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0100);
        vecs[5]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0100);
        vecs[6]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[7]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 4'b0000);
        vecs[8]  = mk(4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 4'b0000);
        vecs[9]  = mk(4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[10] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[11] = mk(4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[12] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[13] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[14] = mk(4'b0001, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0001);
        vecs[15] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0001);
        vecs[16] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0001);
        vecs[17] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0001);
        vecs[18] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0001);
        vecs[19] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[20] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[21] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);
        vecs[22] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000);
        vecs[23] = mk(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0001);
        vecs[24] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000);

        // Reset values
        do_reset();
        check("reset_outputs", 32'(outs()), 32'({2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000}));

        // Per-clock vector table
        for (int i = 0; i < 25; i++) begin
            call_req = vecs[i].call; up = vecs[i].up_i; down = vecs[i].dn_i; tick = vecs[i].tk_i;
            clk1();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        call_req = 4'b0000; up = 1'b0; down = 1'b0; tick = 1'b0;

        // Reset mid-move at floor 1 aborts immediately
        do_reset();
        pulse_call(4'b0100);
        clk1();
        ticks(2);
        check("mid_move_floor", 32'({floor, moving}), 32'({2'd1, 1'b1}));
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'({2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000}));
        clk1();
        reset = 1'b0;
        repeat (3) clk1();
        check("after_reset_idle", 32'(outs()), 32'({2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000}));

        // Single trip with tick every 4 clk
        do_reset();
        pulse_call(4'b0100);
        check("trip_latch", 32'({pending, moving}), 32'({4'b0100, 1'b0}));
        clk1();
        check("trip_start", 32'(moving), 32'd1);
        ticks(2);
        check("trip_floor1", 32'({floor, moving, door_open}), 32'({2'd1, 1'b1, 1'b0}));
        ticks(2);
        check("trip_arrive", 32'({floor, moving, door_open, pending}), 32'({2'd2, 1'b0, 1'b1, 4'b0000}));
        ticks(2);
        check("trip_door_held", 32'(door_open), 32'd1);
        ticks(1);
        check("trip_door_closed", 32'({moving, door_open}), 32'({1'b0, 1'b0}));

        // SCAN ordering: calls 3 and 0 while moving up at floor 1
        do_reset();
        pulse_call(4'b1000);
        clk1();
        ticks(2);
        check("scan_floor1", 32'({floor, dir_up, moving}), 32'({2'd1, 1'b1, 1'b1}));
        pulse_call(4'b0001);
        check("scan_pending", 32'(pending), 32'(4'b1001));
        ticks(4);
        check("scan_serve3", 32'({floor, dir_up, door_open, pending}), 32'({2'd3, 1'b1, 1'b1, 4'b0001}));
        ticks(3);
        check("scan_flip", 32'({dir_up, moving, door_open}), 32'({1'b0, 1'b1, 1'b0}));
        ticks(6);
        check("scan_serve0", 32'({floor, dir_up, door_open, pending}), 32'({2'd0, 1'b0, 1'b1, 4'b0000}));

        // Overload holds the door, occupancy saturation
        do_reset();
        pulse_call(4'b0001);
        clk1();
        check("ovl_door", 32'(door_open), 32'd1);
        up = 1'b1;
        repeat (6) clk1();
        up = 1'b0;
        check("ovl_count6", 32'({count, alarm}), 32'({3'd6, 1'b1}));
        ticks(4);
        check("ovl_held", 32'({door_open, count}), 32'({1'b1, 3'd6}));
        down = 1'b1;
        clk1();
        down = 1'b0;
        check("ovl_count5", 32'({count, alarm, door_open}), 32'({3'd5, 1'b0, 1'b1}));
        clk1();
        check("ovl_close", 32'(door_open), 32'd0);
        pulse_call(4'b0001);
        clk1();
        check("ovl_reopen", 32'(door_open), 32'd1);
        down = 1'b1;
        repeat (10) clk1();
        down = 1'b0;
        check("ovl_sat0", 32'(count), 32'd0);
        up = 1'b1;
        clk1();
        down = 1'b1;
        clk1();
        up = 1'b0; down = 1'b0;
        check("ovl_updown", 32'(count), 32'd1);

        // Own-floor call while door open restarts dwell
        do_reset();
        pulse_call(4'b0001);
        clk1();
        ticks(2);
        pulse_call(4'b0001);
        check("own_no_latch", 32'({door_open, pending}), 32'({1'b1, 4'b0000}));
        ticks(2);
        check("own_still_open", 32'(door_open), 32'd1);
        ticks(1);
        check("own_closed", 32'({door_open, pending}), 32'({1'b0, 4'b0000}));

        // Idle behaviour at floor 3
        do_reset();
        pulse_call(4'b1000);
        clk1();
        ticks(6);
        check("idle_reach3", 32'({floor, door_open}), 32'({2'd3, 1'b1}));
        ticks(3);
        check("idle_closed", 32'({floor, moving, door_open}), 32'({2'd3, 1'b0, 1'b0}));
`ifdef ELEV_PARK_EN
        ticks(7);
        check("park_wait", 32'(moving), 32'd0);
        ticks(1);
        check("park_start", 32'({moving, dir_up}), 32'({1'b1, 1'b0}));
        ticks(6);
        check("park_arrive", 32'({floor, moving, door_open}), 32'({2'd0, 1'b0, 1'b0}));
`else
        begin
            logic stayed = 1'b1;
            for (int k = 0; k < 50; k++) begin
                do_tick();
                if (floor != 2'd3 || moving || door_open) stayed = 1'b0;
            end
            check("no_park_stay3", 32'({stayed, floor}), 32'({1'b1, 2'd3}));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
